mmio_timer: RTL and testbench

Memory-mapped down-counting timer with a prescaler and a level interrupt. It sits on the single-cycle CPU's data-memory port (`m_addr`, `d_t_mem`, `wmem`, `rmem`) beside data memory, and drives the CPU's `intr0` timer-interrupt input. The handler acknowledges an interrupt by a write-1-to-clear on STATUS. The CPU reads `d_f_mem` combinationally in the same cycle, so register reads are asynchronous and writes commit on the clock edge.

---
 rtl/mmio_timer_pkg.sv | 31 +++
 rtl/mmio_timer_if.sv | 25 ++
 rtl/mmio_timer_prescaler.sv | 30 +++
 rtl/mmio_timer.sv | 140 ++++++++++++++
 tb/tb_mmio_timer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets,
// CTRL/STATUS bit positions and the CTRL register layout.
package mmio_timer_pkg;

    // Byte offsets inside the 32-byte window
    localparam logic [4:0] TMR_CTRL     = 5'h00;
    localparam logic [4:0] TMR_PRESCALE = 5'h04;
    localparam logic [4:0] TMR_LOAD     = 5'h08;
    localparam logic [4:0] TMR_COUNT    = 5'h0C;
    localparam logic [4:0] TMR_STATUS   = 5'h10;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    // STATUS bit positions
    localparam int STATUS_PEND = 0;

    typedef struct packed {
        logic ie;
        logic auto_reload;
        logic en;
    } ctrl_t;

    // Word index of a register, as decoded from m_addr[4:2]
    function automatic logic [2:0] reg_index(input logic [4:0] offset);
        return offset[4:2];
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// CPU data-memory port as seen by the timer.
//
// Bus semantics: there is no handshake stall. A write commits on the rising
// clock edge at which wmem is high and the address hits the window (sel).
// A read is combinational: rdata reflects the addressed register in the same
// cycle while rmem is high and sel is set, and is 0 otherwise. The master
// uses sel to steer rdata onto its read path and to block the memory write.
interface mmio_timer_if;
    logic [31:0] m_addr;
    logic [31:0] d_t_mem;
    logic        wmem;
    logic        rmem;
    logic        sel;
    logic [31:0] rdata;

    modport master (
        output m_addr, d_t_mem, wmem, rmem,
        input  sel, rdata
    );

    modport slave (
        input  m_addr, d_t_mem, wmem, rmem,
        output sel, rdata
    );
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Prescaler: divides the clock so that one tick occurs every prescale+1
// clocks while enabled. The tick is a compare of the registered counter,
// so it is valid in the same cycle the counter reaches the limit.
module mmio_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick = en & (pcnt == prescale);

    // Count up while enabled; restart on tick, on disable and on a CTRL write
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pcnt <= '0;
        end else if (clr || !en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with prescaler and level interrupt.
// Holds the register file, the down-counter, the pending flag and the
// combinational read mux; the prescaler lives in its own sub-module.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          PRESCALE_W = 16
) (
    input  logic         clock,
    input  logic         resetn,
    mmio_timer_if.slave  bus,
    output logic         intr0
);

    localparam logic [2:0] IDX_CTRL     = reg_index(TMR_CTRL);
    localparam logic [2:0] IDX_PRESCALE = reg_index(TMR_PRESCALE);
    localparam logic [2:0] IDX_LOAD     = reg_index(TMR_LOAD);
    localparam logic [2:0] IDX_COUNT    = reg_index(TMR_COUNT);
    localparam logic [2:0] IDX_STATUS   = reg_index(TMR_STATUS);

    ctrl_t                 ctrl;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           load;
    logic [31:0]           count;
    logic                  pend;

    logic [2:0]  off;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_load;
    logic        wr_count;
    logic        wr_status;
    logic        tick;
    logic        expiry;
    logic [31:0] rdata;
    logic        unused_addr_bits;

    // Byte lane bits carry no meaning for word registers
    assign unused_addr_bits = ^bus.m_addr[1:0];

    assign bus.sel = (bus.m_addr[31:5] == BASE_ADDR[31:5]);
    assign off     = bus.m_addr[4:2];
    assign wr      = bus.wmem & bus.sel;

    assign wr_ctrl     = wr && (off == IDX_CTRL);
    assign wr_prescale = wr && (off == IDX_PRESCALE);
    assign wr_load     = wr && (off == IDX_LOAD);
    assign wr_count    = wr && (off == IDX_COUNT);
    assign wr_status   = wr && (off == IDX_STATUS);

    // COUNT of 0 or 1 on a tick expires; a bus write to COUNT overrides the tick
    assign expiry = tick && (count <= 32'd1) && !wr_count;

    mmio_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clock    (clock),
        .resetn   (resetn),
        .en       (ctrl.en),
        .clr      (wr_ctrl),
        .prescale (prescale),
        .tick     (tick)
    );

    // CTRL: bus write wins over the one-shot self-disable
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl.en          <= bus.d_t_mem[CTRL_EN];
            ctrl.auto_reload <= bus.d_t_mem[CTRL_AUTO];
            ctrl.ie          <= bus.d_t_mem[CTRL_IE];
        end else if (expiry && !ctrl.auto_reload) begin
            ctrl.en <= 1'b0;
        end
    end

    // PRESCALE and LOAD are plain bus-written registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prescale <= '0;
            load     <= '0;
        end else begin
            if (wr_prescale) prescale <= bus.d_t_mem[PRESCALE_W-1:0];
            if (wr_load)     load     <= bus.d_t_mem;
        end
    end

    // Down-counter: bus write first, then reload/clear on expiry, else decrement
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (wr_count) begin
            count <= bus.d_t_mem;
        end else if (tick) begin
            if (count <= 32'd1) begin
                count <= ctrl.auto_reload ? load : 32'd0;
            end else begin
                count <= count - 32'd1;
            end
        end
    end

    // PEND: set on expiry takes priority over write-1-to-clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend <= 1'b0;
        end else if (expiry) begin
            pend <= 1'b1;
        end else if (wr_status && bus.d_t_mem[STATUS_PEND]) begin
            pend <= 1'b0;
        end
    end

    assign intr0 = pend & ctrl.ie;

    // Read mux: zero unless the window is selected for a read
    always_comb begin
        rdata = '0;
        if (bus.sel && bus.rmem) begin
            case (off)
                IDX_CTRL: begin
                    rdata[CTRL_EN]   = ctrl.en;
                    rdata[CTRL_AUTO] = ctrl.auto_reload;
                    rdata[CTRL_IE]   = ctrl.ie;
                end
                IDX_PRESCALE: rdata[PRESCALE_W-1:0] = prescale;
                IDX_LOAD:     rdata = load;
                IDX_COUNT:    rdata = count;
                IDX_STATUS:   rdata[STATUS_PEND] = pend;
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.rdata = rdata;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed testbench for mmio_timer: register access, one-shot, auto-reload,
// interrupt gating, same-edge collisions and asynchronous reset.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [4:0] O_CTRL   = 5'h00;
    localparam logic [4:0] O_PRE    = 5'h04;
    localparam logic [4:0] O_LOAD   = 5'h08;
    localparam logic [4:0] O_COUNT  = 5'h0C;
    localparam logic [4:0] O_STATUS = 5'h10;

    logic clock = 1'b0;
    logic resetn;
    logic intr0;
    int   checks = 0;
    int   errors = 0;

    mmio_timer_if bus ();

    mmio_timer #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (16)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus),
        .intr0  (intr0)
    );

    always #5 clock = ~clock;

    // Write: drive now, commit on the next rising edge, return 1ns after it
    task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
        bus.m_addr  = BASE + 32'(off);
        bus.d_t_mem = data;
        bus.wmem    = 1'b1;
        @(posedge clock);
        #1;
        bus.wmem    = 1'b0;
    endtask

    // Read: combinational, consumes 1ns and no clock edge
    task automatic bus_read(input logic [4:0] off, output logic [31:0] data);
        bus.m_addr = BASE + 32'(off);
        bus.rmem   = 1'b1;
        #1;
        data       = bus.rdata;
        bus.rmem   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        resetn      = 1'b0;
        bus.m_addr  = '0;
        bus.d_t_mem = '0;
        bus.wmem    = 1'b0;
        bus.rmem    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (intr0 !== 1'b0) begin errors++; $display("FAIL reset_intr0 got %b want 0", intr0); end
        @(negedge clock);
        resetn = 1'b1;
        cycles(1);
        for (int i = 0; i < 8; i++) begin
            bus_read(5'(i * 4), rd);
            checks++;
            if (rd !== 32'h0) begin errors++; $display("FAIL reset_read off=%0h got %h want 0", i * 4, rd); end
        end
        bus_write(5'h14, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            bus_read(5'(i * 4), rd);
            checks++;
            if (rd !== 32'h0) begin errors++; $display("FAIL unused_write off=%0h got %h want 0", i * 4, rd); end
        end
        checks++;
        if (intr0 !== 1'b0) begin errors++; $display("FAIL reset_intr0_after got %b want 0", intr0); end
        bus.m_addr = BASE + 32'h20;
        bus.rmem   = 1'b1;
        #1;
        checks++;
        if (bus.sel !== 1'b0) begin errors++; $display("FAIL sel_outside got %b want 0", bus.sel); end
        bus.m_addr = BASE + 32'h1C;
        #1;
        checks++;
        if (bus.sel !== 1'b1) begin errors++; $display("FAIL sel_inside got %b want 1", bus.sel); end
        bus.rmem = 1'b0;
    endtask

    task automatic test_registers();
        logic [31:0] rd;
        bus_write(O_PRE, 32'hFFFF_FFFF);
        bus_read(O_PRE, rd);
        checks++;
        if (rd !== 32'h0000_FFFF) begin errors++; $display("FAIL prescale_width got %h want 0000ffff", rd); end
        bus_write(O_LOAD, 32'hDEAD_BEEF);
        bus_read(O_LOAD, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rw got %h want deadbeef", rd); end
        bus_read(5'h0B, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL low_addr_bits got %h want deadbeef", rd); end
        bus.m_addr = BASE + 32'(O_LOAD);
        bus.rmem   = 1'b0;
        #1;
        checks++;
        if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rdata_no_rmem got %h want 0", bus.rdata); end
        bus_write(O_CTRL, 32'hFFFF_FFFA);
        bus_read(O_CTRL, rd);
        checks++;
        if (rd !== 32'h0000_0002) begin errors++; $display("FAIL ctrl_bits got %h want 2", rd); end
        bus_write(O_CTRL, 32'h0);
        // Read and write on the same cycle: old value visible until the edge
        bus.m_addr  = BASE + 32'(O_PRE);
        bus.d_t_mem = 32'h7;
        bus.wmem    = 1'b1;
        bus.rmem    = 1'b1;
        #1;
        checks++;
        if (bus.rdata !== 32'h0000_FFFF) begin errors++; $display("FAIL rw_same_cycle got %h want 0000ffff", bus.rdata); end
        @(posedge clock);
        #1;
        bus.wmem = 1'b0;
        checks++;
        if (bus.rdata !== 32'h7) begin errors++; $display("FAIL rw_after_edge got %h want 7", bus.rdata); end
        bus.rmem = 1'b0;
        bus_write(O_LOAD, 32'h0);
    endtask

    task automatic test_one_shot();
        logic [31:0] rd;
        bus_write(O_PRE, 32'h0);
        bus_write(O_COUNT, 32'd3);
        bus_write(O_CTRL, 32'h5);
        for (int k = 1; k <= 3; k++) begin
            cycles(1);
            checks++;
            if (intr0 !== (k == 3)) begin errors++; $display("FAIL oneshot_intr0 k=%0d got %b want %b", k, intr0, k == 3); end
            if (k < 3) begin
                bus_read(O_COUNT, rd);
                checks++;
                if (rd !== 32'(3 - k)) begin errors++; $display("FAIL oneshot_count k=%0d got %h want %h", k, rd, 3 - k); end
            end
        end
        bus_read(O_COUNT, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL oneshot_count_end got %h want 0", rd); end
        bus_read(O_CTRL, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL oneshot_ctrl_end got %h want 4", rd); end
        bus_read(O_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL oneshot_pend got %h want 1", rd); end
        bus_write(O_STATUS, 32'h1);
        checks++;
        if (intr0 !== 1'b0) begin errors++; $display("FAIL oneshot_w1c got %b want 0", intr0); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] rd;
        logic [31:0] exp_cnt;
        bus_write(O_PRE, 32'd3);
        bus_write(O_LOAD, 32'd2);
        bus_write(O_COUNT, 32'd2);
        bus_write(O_CTRL, 32'h7);
        for (int k = 1; k <= 16; k++) begin
            cycles(1);
            checks++;
            if (intr0 !== (k >= 8)) begin errors++; $display("FAIL auto_intr0 k=%0d got %b want %b", k, intr0, k >= 8); end
            if (k % 4 == 0) begin
                exp_cnt = (k % 8 == 0) ? 32'd2 : 32'd1;
                bus_read(O_COUNT, rd);
                checks++;
                if (rd !== exp_cnt) begin errors++; $display("FAIL auto_count k=%0d got %h want %h", k, rd, exp_cnt); end
            end
        end
        bus_write(O_STATUS, 32'h1);
        checks++;
        if (intr0 !== 1'b0) begin errors++; $display("FAIL auto_w1c got %b want 0", intr0); end
        bus_write(O_CTRL, 32'h0);
        bus_write(O_COUNT, 32'h0);
        bus_write(O_PRE, 32'h0);
    endtask

    task automatic test_ie_gating();
        logic [31:0] rd;
        bus_write(O_COUNT, 32'd1);
        bus_write(O_CTRL, 32'h1);
        cycles(1);
        checks++;
        if (intr0 !== 1'b0) begin errors++; $display("FAIL ie_off_intr0 got %b want 0", intr0); end
        bus_read(O_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL ie_off_pend got %h want 1", rd); end
        bus_read(O_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL ie_off_ctrl got %h want 0", rd); end
        bus_write(O_CTRL, 32'h4);
        checks++;
        if (intr0 !== 1'b1) begin errors++; $display("FAIL ie_on_intr0 got %b want 1", intr0); end
        bus_write(O_STATUS, 32'h1);
        checks++;
        if (intr0 !== 1'b0) begin errors++; $display("FAIL ie_w1c got %b want 0", intr0); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        bus_write(O_COUNT, 32'd2);
        bus_write(O_CTRL, 32'h5);
        cycles(1);
        bus_read(O_COUNT, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL w1c_coll_count got %h want 1", rd); end
        bus_write(O_STATUS, 32'h1);
        bus_read(O_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL w1c_coll_pend got %h want 1", rd); end
        checks++;
        if (intr0 !== 1'b1) begin errors++; $display("FAIL w1c_coll_intr0 got %b want 1", intr0); end
        bus_write(O_STATUS, 32'h1);
        checks++;
        if (intr0 !== 1'b0) begin errors++; $display("FAIL w1c_coll_clear got %b want 0", intr0); end
    endtask

    task automatic test_count_collision();
        logic [31:0] rd;
        bus_write(O_COUNT, 32'd1);
        bus_write(O_CTRL, 32'h5);
        bus_write(O_COUNT, 32'h10);
        bus_read(O_COUNT, rd);
        checks++;
        if (rd !== 32'h10) begin errors++; $display("FAIL count_coll_value got %h want 10", rd); end
        bus_read(O_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL count_coll_pend got %h want 0", rd); end
        checks++;
        if (intr0 !== 1'b0) begin errors++; $display("FAIL count_coll_intr0 got %b want 0", intr0); end
        cycles(1);
        bus_read(O_COUNT, rd);
        checks++;
        if (rd !== 32'h0F) begin errors++; $display("FAIL count_coll_next got %h want f", rd); end
        bus_write(O_CTRL, 32'h0);
        bus_write(O_COUNT, 32'h0);
    endtask

    task automatic test_ctrl_collision();
        logic [31:0] rd;
        bus_write(O_COUNT, 32'd1);
        bus_write(O_CTRL, 32'h5);
        bus_write(O_CTRL, 32'h6);
        bus_read(O_CTRL, rd);
        checks++;
        if (rd !== 32'h6) begin errors++; $display("FAIL ctrl_coll_ctrl got %h want 6", rd); end
        bus_read(O_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_coll_pend got %h want 1", rd); end
        bus_read(O_COUNT, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_coll_count got %h want 0", rd); end
        checks++;
        if (intr0 !== 1'b1) begin errors++; $display("FAIL ctrl_coll_intr0 got %b want 1", intr0); end
        bus_write(O_STATUS, 32'h1);
        bus_write(O_CTRL, 32'h0);
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] rd;
        bus_write(O_COUNT, 32'd1);
        bus_write(O_CTRL, 32'h5);
        cycles(1);
        checks++;
        if (intr0 !== 1'b1) begin errors++; $display("FAIL midrst_pre_intr0 got %b want 1", intr0); end
        bus_write(O_COUNT, 32'd5);
        bus_write(O_CTRL, 32'h5);
        cycles(1);
        bus_read(O_COUNT, rd);
        checks++;
        if (rd !== 32'd4) begin errors++; $display("FAIL midrst_running got %h want 4", rd); end
        resetn = 1'b0;
        #1;
        checks++;
        if (intr0 !== 1'b0) begin errors++; $display("FAIL midrst_intr0 got %b want 0", intr0); end
        bus_read(O_COUNT, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_count got %h want 0", rd); end
        bus_read(O_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_ctrl got %h want 0", rd); end
        bus_read(O_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_pend got %h want 0", rd); end
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycles(1);
            checks++;
            if (intr0 !== 1'b0) begin errors++; $display("FAIL midrst_after k=%0d got %b want 0", k, intr0); end
        end
        bus_read(O_COUNT, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_count_after got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_one_shot();
        test_auto_reload();
        test_ie_gating();
        test_w1c_collision();
        test_count_collision();
        test_ctrl_collision();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
